multicycle_control_v2: RTL and testbench

Parametrised successor to the multicycle MIPS control FSM. Drives datapath enables and mux selects for fetch, decode and execute of R-type add/sub/and, addi, lw, sw, beq and j. Memory latency is a parameter, not a fixed count. Adds writeback muxing, branch/jump PC sourcing and an illegal-instruction exception path. Sits beside the datapath top level and consumes IR[31:26] and IR[15:0].

---
 rtl/cpu_ctrl_pkg.sv | 93 +++++++++
 rtl/wait_counter.sv | 44 ++++
 rtl/multicycle_control_v2.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control_v2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Holds the FSM state enum, opcode/funct constants, the ULAop / srcB /
// PCSource mux encodings and the registered control-word struct. The
// datapath imports this package so both sides agree on every encoding.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_IR_LOAD   = 4'd2,
    S_DECODE    = 4'd3,
    S_R_EXEC    = 4'd4,
    S_R_WB      = 4'd5,
    S_ADDI_EXEC = 4'd6,
    S_ADDI_WB   = 4'd7,
    S_MEM_ADDR  = 4'd8,
    S_LW_READ   = 4'd9,
    S_LW_WB     = 4'd10,
    S_SW_WRITE  = 4'd11,
    S_BEQ       = 4'd12,
    S_JUMP      = 4'd13,
    S_EXCEPT    = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RESET = 6'h3F;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALU operation select
  localparam logic [2:0] ULA_PASS_A = 3'b000;
  localparam logic [2:0] ULA_ADD    = 3'b001;
  localparam logic [2:0] ULA_SUB    = 3'b010;
  localparam logic [2:0] ULA_AND    = 3'b011;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // Registered control word (everything except the sticky illegal flag)
  typedef struct packed {
    logic       pc_control;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       read_write;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       a_write;
    logic       b_write;
    logic       ula_out;
    logic [2:0] ula_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       epc_write;
    logic       reset_out;
  } ctrl_t;

  // Supported R-type functs
  function automatic logic is_r_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  // ALU operation for a supported R-type funct
  function automatic logic [2:0] r_ula_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with a done flag, used to time memory waits.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   load          - load load_value on this edge (takes priority)
//   enable        - decrement on this edge, saturating at zero
//   load_value    - value loaded when load is high
//   next_count    - value the counter will hold after this edge
//   done          - counter currently reads zero (last wait cycle)
module wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // next_count is exported so the controller can see, one edge early,
  // whether the cycle being entered is the last of a wait.
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_value;
    end else if (enable && (count != '0)) begin
      next_count = count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multicycle_control_v2.sv
// Multicycle MIPS control FSM (add/sub/and, addi, lw, sw, beq, j).
// Moore machine: every output is registered and is decoded from the state
// being entered on each edge, so the datapath sees glitch-free enables.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   OPCODE, OFFSET    - IR[31:26] and IR[15:0] (funct = OFFSET[5:0])
//   zero              - ALU zero flag (consumed by the datapath via PCWriteCond)
//   PC_control .. EPCWrite - datapath enables and mux selects
//   illegal           - sticky illegal-instruction flag, cleared by reset
//   reset_out         - datapath reset request
module multicycle_control_v2
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 3,
  parameter int RST_HOLD   = 1,
  parameter int EXC_ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  OPCODE,
  input  logic [15:0] OFFSET,
  input  logic        zero,
  output logic        PC_control,
  output logic        PCWriteCond,
  output logic [1:0]  PCSource,
  output logic        ReadWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        MDRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        AWrite,
  output logic        BWrite,
  output logic        ULAout_ctrl,
  output logic [2:0]  ULAop,
  output logic        srcA_selector,
  output logic [1:0]  srcB_selector,
  output logic        EPCWrite,
  output logic        illegal,
  output logic        reset_out
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_t            state, next_state;
  ctrl_t             ctrl_q, ctrl_next;
  logic              illegal_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  wait_next;
  logic              wait_done;
  logic [5:0]        funct;
  logic              bad_instr_unused;
  state_t            bad_target;

  assign funct = OFFSET[5:0];

  // zero is gated in the datapath; upper OFFSET bits are datapath-only
  assign bad_instr_unused = ^{OFFSET[15:6], zero};

  assign bad_target = (EXC_ENABLE != 0) ? S_EXCEPT : S_FETCH;

  // The wait counter reloads on every state change, so whichever wait
  // state is entered (FETCH or LW_READ) starts with MEM_WAIT-1 to go.
  wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clock      (clock),
    .reset      (reset),
    .load       (next_state != state),
    .enable     ((state == S_FETCH) || (state == S_LW_READ)),
    .load_value (WAIT_LAST),
    .next_count (wait_next),
    .done       (wait_done)
  );

  // State register, reset-hold counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_RESET;
      hold_cnt  <= '0;
      ctrl_q    <= '0;
      ctrl_q.reset_out <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_next;
      if ((state == S_RESET) && (next_state == S_RESET)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
      if (next_state == S_EXCEPT) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_RESET:     if (hold_cnt == HOLD_LAST) next_state = S_FETCH;
      S_FETCH:     if (wait_done) next_state = S_IR_LOAD;
      S_IR_LOAD:   next_state = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_R:     next_state = is_r_funct(funct) ? S_R_EXEC : bad_target;
          OP_ADDI:  next_state = S_ADDI_EXEC;
          OP_LW:    next_state = S_MEM_ADDR;
          OP_SW:    next_state = S_MEM_ADDR;
          OP_BEQ:   next_state = S_BEQ;
          OP_J:     next_state = S_JUMP;
          OP_RESET: next_state = S_RESET;
          default:  next_state = bad_target;
        endcase
      end
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_MEM_ADDR:  next_state = (OPCODE == OP_LW) ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:   if (wait_done) next_state = S_LW_WB;
      S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE,
      S_BEQ, S_JUMP, S_EXCEPT:
                   next_state = S_FETCH;
      default:     next_state = S_RESET;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    ctrl_next = '0;
    case (next_state)
      S_FETCH: begin
        ctrl_next.src_b  = SRCB_FOUR;
        ctrl_next.ula_op = ULA_ADD;
      end
      S_IR_LOAD: begin
        // ALU keeps computing PC+4 so PCSource=ALU result writes PC+4
        ctrl_next.pc_control = 1'b1;
        ctrl_next.pc_source  = PCSRC_ALU;
        ctrl_next.ir_write   = 1'b1;
        ctrl_next.src_b      = SRCB_FOUR;
        ctrl_next.ula_op     = ULA_ADD;
      end
      S_DECODE: begin
        ctrl_next.a_write = 1'b1;
        ctrl_next.b_write = 1'b1;
        ctrl_next.src_b   = SRCB_IMM_SH2;
        ctrl_next.ula_op  = ULA_ADD;
        ctrl_next.ula_out = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_next.src_a   = 1'b1;
        ctrl_next.src_b   = SRCB_B;
        ctrl_next.ula_op  = r_ula_op(funct);
        ctrl_next.ula_out = 1'b1;
      end
      S_R_WB: begin
        ctrl_next.reg_write = 1'b1;
        ctrl_next.reg_dst   = 1'b1;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        ctrl_next.src_a   = 1'b1;
        ctrl_next.src_b   = SRCB_IMM;
        ctrl_next.ula_op  = ULA_ADD;
        ctrl_next.ula_out = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl_next.reg_write = 1'b1;
      end
      S_LW_READ: begin
        // MDR captures on the final wait cycle, when memory data is valid
        ctrl_next.iord      = 1'b1;
        ctrl_next.mdr_write = (wait_next == '0);
      end
      S_LW_WB: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = 1'b1;
      end
      S_SW_WRITE: begin
        ctrl_next.iord       = 1'b1;
        ctrl_next.read_write = 1'b1;
      end
      S_BEQ: begin
        ctrl_next.src_a         = 1'b1;
        ctrl_next.src_b         = SRCB_B;
        ctrl_next.ula_op        = ULA_SUB;
        ctrl_next.pc_write_cond = 1'b1;
        ctrl_next.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_next.pc_control = 1'b1;
        ctrl_next.pc_source  = PCSRC_JUMP;
      end
      S_EXCEPT: begin
        // PC was already advanced; PC-4 is the faulting instruction
        ctrl_next.epc_write  = 1'b1;
        ctrl_next.src_b      = SRCB_FOUR;
        ctrl_next.ula_op     = ULA_SUB;
        ctrl_next.pc_control = 1'b1;
        ctrl_next.pc_source  = PCSRC_EXC;
      end
      default: begin
        ctrl_next.reset_out = 1'b1;
      end
    endcase
  end

  assign PC_control    = ctrl_q.pc_control;
  assign PCWriteCond   = ctrl_q.pc_write_cond;
  assign PCSource      = ctrl_q.pc_source;
  assign ReadWrite     = ctrl_q.read_write;
  assign IorD          = ctrl_q.iord;
  assign IRWrite       = ctrl_q.ir_write;
  assign MDRWrite      = ctrl_q.mdr_write;
  assign RegWrite      = ctrl_q.reg_write;
  assign RegDst        = ctrl_q.reg_dst;
  assign MemToReg      = ctrl_q.mem_to_reg;
  assign AWrite        = ctrl_q.a_write;
  assign BWrite        = ctrl_q.b_write;
  assign ULAout_ctrl   = ctrl_q.ula_out;
  assign ULAop         = ctrl_q.ula_op;
  assign srcA_selector = ctrl_q.src_a;
  assign srcB_selector = ctrl_q.src_b;
  assign EPCWrite      = ctrl_q.epc_write;
  assign illegal       = illegal_q;
  assign reset_out     = ctrl_q.reset_out;

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Directed bench for multicycle_control_v2. Three instances share clock,
// reset and instruction inputs: A (MEM_WAIT=3, EXC_ENABLE=1),
// B (MEM_WAIT=5, EXC_ENABLE=1) and C (MEM_WAIT=3, EXC_ENABLE=0).
// Each instruction starts from a reset; cycle index 0 is the first FETCH cycle.
module tb_multicycle_control_v2;

  typedef struct packed {
    logic       pcControl;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       readWrite;
    logic       iorD;
    logic       irWrite;
    logic       mdrWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aWrite;
    logic       bWrite;
    logic       ulaOut;
    logic [2:0] ulaOp;
    logic       srcA;
    logic [1:0] srcB;
    logic       epcWrite;
    logic       illegal;
    logic       resetOut;
  } obs_t;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic [15:0] offset;
  logic        zero;

  logic aPcControl, aPcWriteCond, aReadWrite, aIorD, aIrWrite, aMdrWrite, aRegWrite, aRegDst, aMemToReg, aAWrite, aBWrite, aUlaOut, aSrcA, aEpcWrite, aIllegal, aResetOut;
  logic [1:0] aPcSource, aSrcB;
  logic [2:0] aUlaOp;
  logic bPcControl, bPcWriteCond, bReadWrite, bIorD, bIrWrite, bMdrWrite, bRegWrite, bRegDst, bMemToReg, bAWrite, bBWrite, bUlaOut, bSrcA, bEpcWrite, bIllegal, bResetOut;
  logic [1:0] bPcSource, bSrcB;
  logic [2:0] bUlaOp;
  logic cPcControl, cPcWriteCond, cReadWrite, cIorD, cIrWrite, cMdrWrite, cRegWrite, cRegDst, cMemToReg, cAWrite, cBWrite, cUlaOut, cSrcA, cEpcWrite, cIllegal, cResetOut;
  logic [1:0] cPcSource, cSrcB;
  logic [2:0] cUlaOp;

  obs_t obsA, obsB, obsC;
  obs_t trA [32];
  obs_t trB [32];
  obs_t trC [32];

  int checks = 0;
  int failures = 0;

  assign obsA = {aPcControl, aPcWriteCond, aPcSource, aReadWrite, aIorD, aIrWrite, aMdrWrite, aRegWrite, aRegDst, aMemToReg, aAWrite, aBWrite, aUlaOut, aUlaOp, aSrcA, aSrcB, aEpcWrite, aIllegal, aResetOut};
  assign obsB = {bPcControl, bPcWriteCond, bPcSource, bReadWrite, bIorD, bIrWrite, bMdrWrite, bRegWrite, bRegDst, bMemToReg, bAWrite, bBWrite, bUlaOut, bUlaOp, bSrcA, bSrcB, bEpcWrite, bIllegal, bResetOut};
  assign obsC = {cPcControl, cPcWriteCond, cPcSource, cReadWrite, cIorD, cIrWrite, cMdrWrite, cRegWrite, cRegDst, cMemToReg, cAWrite, cBWrite, cUlaOut, cUlaOp, cSrcA, cSrcB, cEpcWrite, cIllegal, cResetOut};

  multicycle_control_v2 #(.MEM_WAIT(3), .RST_HOLD(1), .EXC_ENABLE(1)) dutA (
    .clock(clock), .reset(reset), .OPCODE(opcode), .OFFSET(offset), .zero(zero),
    .PC_control(aPcControl), .PCWriteCond(aPcWriteCond), .PCSource(aPcSource),
    .ReadWrite(aReadWrite), .IorD(aIorD), .IRWrite(aIrWrite), .MDRWrite(aMdrWrite),
    .RegWrite(aRegWrite), .RegDst(aRegDst), .MemToReg(aMemToReg), .AWrite(aAWrite),
    .BWrite(aBWrite), .ULAout_ctrl(aUlaOut), .ULAop(aUlaOp), .srcA_selector(aSrcA),
    .srcB_selector(aSrcB), .EPCWrite(aEpcWrite), .illegal(aIllegal), .reset_out(aResetOut)
  );

  multicycle_control_v2 #(.MEM_WAIT(5), .RST_HOLD(1), .EXC_ENABLE(1)) dutB (
    .clock(clock), .reset(reset), .OPCODE(opcode), .OFFSET(offset), .zero(zero),
    .PC_control(bPcControl), .PCWriteCond(bPcWriteCond), .PCSource(bPcSource),
    .ReadWrite(bReadWrite), .IorD(bIorD), .IRWrite(bIrWrite), .MDRWrite(bMdrWrite),
    .RegWrite(bRegWrite), .RegDst(bRegDst), .MemToReg(bMemToReg), .AWrite(bAWrite),
    .BWrite(bBWrite), .ULAout_ctrl(bUlaOut), .ULAop(bUlaOp), .srcA_selector(bSrcA),
    .srcB_selector(bSrcB), .EPCWrite(bEpcWrite), .illegal(bIllegal), .reset_out(bResetOut)
  );

  multicycle_control_v2 #(.MEM_WAIT(3), .RST_HOLD(1), .EXC_ENABLE(0)) dutC (
    .clock(clock), .reset(reset), .OPCODE(opcode), .OFFSET(offset), .zero(zero),
    .PC_control(cPcControl), .PCWriteCond(cPcWriteCond), .PCSource(cPcSource),
    .ReadWrite(cReadWrite), .IorD(cIorD), .IRWrite(cIrWrite), .MDRWrite(cMdrWrite),
    .RegWrite(cRegWrite), .RegDst(cRegDst), .MemToReg(cMemToReg), .AWrite(cAWrite),
    .BWrite(cBWrite), .ULAout_ctrl(cUlaOut), .ULAop(cUlaOp), .srcA_selector(cSrcA),
    .srcB_selector(cSrcB), .EPCWrite(cEpcWrite), .illegal(cIllegal), .reset_out(cResetOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected control words, written straight from the state descriptions
  function automatic obs_t expReset();
    obs_t o = '0;
    o.resetOut = 1'b1;
    return o;
  endfunction

  function automatic obs_t expFetch(input logic ill);
    obs_t o = '0;
    o.srcB = 2'b01; o.ulaOp = 3'b001; o.illegal = ill;
    return o;
  endfunction

  function automatic obs_t expIrLoad();
    obs_t o = '0;
    o.pcControl = 1'b1; o.pcSource = 2'b00; o.irWrite = 1'b1;
    o.srcB = 2'b01; o.ulaOp = 3'b001;
    return o;
  endfunction

  function automatic obs_t expDecode();
    obs_t o = '0;
    o.aWrite = 1'b1; o.bWrite = 1'b1; o.srcB = 2'b11; o.ulaOp = 3'b001; o.ulaOut = 1'b1;
    return o;
  endfunction

  function automatic obs_t expExec(input logic [2:0] op, input logic [1:0] b);
    obs_t o = '0;
    o.srcA = 1'b1; o.srcB = b; o.ulaOp = op; o.ulaOut = 1'b1;
    return o;
  endfunction

  function automatic obs_t expWb(input logic dst, input logic m2r);
    obs_t o = '0;
    o.regWrite = 1'b1; o.regDst = dst; o.memToReg = m2r;
    return o;
  endfunction

  function automatic obs_t expMem(input logic rw, input logic mdr);
    obs_t o = '0;
    o.iorD = 1'b1; o.readWrite = rw; o.mdrWrite = mdr;
    return o;
  endfunction

  function automatic obs_t expBeq();
    obs_t o = '0;
    o.srcA = 1'b1; o.srcB = 2'b00; o.ulaOp = 3'b010; o.pcWriteCond = 1'b1; o.pcSource = 2'b01;
    return o;
  endfunction

  function automatic obs_t expJump();
    obs_t o = '0;
    o.pcControl = 1'b1; o.pcSource = 2'b10;
    return o;
  endfunction

  function automatic obs_t expExcept();
    obs_t o = '0;
    o.epcWrite = 1'b1; o.srcB = 2'b01; o.ulaOp = 3'b010;
    o.pcControl = 1'b1; o.pcSource = 2'b11; o.illegal = 1'b1;
    return o;
  endfunction

  // Count cycles in which a chosen enable is high: field 0 RegWrite,
  // 1 MDRWrite, 2 IorD, 3 EPCWrite; dut 0=A 1=B 2=C
  function automatic int countHigh(input int dut, input int field, input int n);
    int total = 0;
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o = (dut == 0) ? trA[i] : (dut == 1) ? trB[i] : trC[i];
      case (field)
        0: total += int'(o.regWrite);
        1: total += int'(o.mdrWrite);
        2: total += int'(o.iorD);
        default: total += int'(o.epcWrite);
      endcase
    end
    return total;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Reset for two cycles with the instruction fields already on the IR,
  // optionally check the reset_out cycle, then record n cycles from FETCH entry.
  task automatic applyStimulus(input logic [5:0] op, input logic [15:0] off, input logic z,
                               input bit checkReset, input int n);
    reset = 1'b1; opcode = op; offset = off; zero = z;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    if (checkReset) checkOutput("reset_state", 32'(obsA), 32'(expReset()));
    stepCycle();
    for (int i = 0; i < n; i++) begin
      trA[i] = obsA; trB[i] = obsB; trC[i] = obsC;
      stepCycle();
    end
  endtask

  initial begin
    int mdrAfter;
    int regAfter;
    reset = 1'b1; opcode = '0; offset = '0; zero = 1'b0;

    // add: FETCH 0-2, IR_LOAD 3 (cycle 5 after reset falls), DECODE 4, R_EXEC 5, R_WB 6
    applyStimulus(6'h00, 16'h0020, 1'b0, 1'b1, 8);
    checkOutput("add_fetch", 32'(trA[0]), 32'(expFetch(1'b0)));
    checkOutput("add_fetch_hold", 32'(trA[2]), 32'(expFetch(1'b0)));
    checkOutput("add_irload", 32'(trA[3]), 32'(expIrLoad()));
    checkOutput("add_decode", 32'(trA[4]), 32'(expDecode()));
    checkOutput("add_rexec", 32'(trA[5]), 32'(expExec(3'b001, 2'b00)));
    checkOutput("add_rwb", 32'(trA[6]), 32'(expWb(1'b1, 1'b0)));
    checkOutput("add_regwrite_cnt", 32'(countHigh(0, 0, 8)), 32'd1);
    checkOutput("add_refetch", 32'(trA[7]), 32'(expFetch(1'b0)));
    checkOutput("add_c_rwb", 32'(trC[6]), 32'(expWb(1'b1, 1'b0)));

    // sub / and select their own ALU operation in R_EXEC
    applyStimulus(6'h00, 16'h0022, 1'b0, 1'b0, 8);
    checkOutput("sub_ulaop", 32'(trA[5].ulaOp), 32'h2);
    checkOutput("sub_regwrite_cnt", 32'(countHigh(0, 0, 8)), 32'd1);
    applyStimulus(6'h00, 16'h0024, 1'b0, 1'b0, 8);
    checkOutput("and_ulaop", 32'(trA[5].ulaOp), 32'h3);

    // addi
    applyStimulus(6'h08, 16'h0005, 1'b0, 1'b0, 8);
    checkOutput("addi_exec", 32'(trA[5]), 32'(expExec(3'b001, 2'b10)));
    checkOutput("addi_wb", 32'(trA[6]), 32'(expWb(1'b0, 1'b0)));
    checkOutput("addi_refetch", 32'(trA[7]), 32'(expFetch(1'b0)));

    // lw: B (MEM_WAIT=5) LW_READ 8-12, LW_WB 13, FETCH 14; A (MEM_WAIT=3) LW_WB 9
    applyStimulus(6'h23, 16'h0010, 1'b0, 1'b0, 15);
    checkOutput("lw_b_memaddr", 32'(trB[7]), 32'(expExec(3'b001, 2'b10)));
    checkOutput("lw_b_read_first", 32'(trB[8]), 32'(expMem(1'b0, 1'b0)));
    checkOutput("lw_b_read_last", 32'(trB[12]), 32'(expMem(1'b0, 1'b1)));
    checkOutput("lw_b_iord_cnt", 32'(countHigh(1, 2, 15)), 32'd5);
    checkOutput("lw_b_mdr_cnt", 32'(countHigh(1, 1, 15)), 32'd1);
    checkOutput("lw_b_wb", 32'(trB[13]), 32'(expWb(1'b0, 1'b1)));
    checkOutput("lw_b_refetch", 32'(trB[14]), 32'(expFetch(1'b0)));
    checkOutput("lw_a_wb", 32'(trA[9]), 32'(expWb(1'b0, 1'b1)));
    checkOutput("lw_a_refetch", 32'(trA[10]), 32'(expFetch(1'b0)));

    // sw
    applyStimulus(6'h2B, 16'h0010, 1'b0, 1'b0, 8);
    checkOutput("sw_write", 32'(trA[6]), 32'(expMem(1'b1, 1'b0)));
    checkOutput("sw_refetch", 32'(trA[7]), 32'(expFetch(1'b0)));

    // beq behaves the same for either zero value; no register write
    applyStimulus(6'h04, 16'h0003, 1'b1, 1'b0, 7);
    checkOutput("beq_z1", 32'(trA[5]), 32'(expBeq()));
    checkOutput("beq_z1_regwrite_cnt", 32'(countHigh(0, 0, 7)), 32'd0);
    checkOutput("beq_refetch", 32'(trA[6]), 32'(expFetch(1'b0)));
    applyStimulus(6'h04, 16'h0003, 1'b0, 1'b0, 7);
    checkOutput("beq_z0", 32'(trA[5]), 32'(expBeq()));
    checkOutput("beq_z0_regwrite_cnt", 32'(countHigh(0, 0, 7)), 32'd0);

    // j
    applyStimulus(6'h02, 16'h0040, 1'b0, 1'b0, 7);
    checkOutput("j_jump", 32'(trA[5]), 32'(expJump()));
    checkOutput("j_refetch", 32'(trA[6]), 32'(expFetch(1'b0)));

    // reset opcode re-enters RESET for one cycle
    applyStimulus(6'h3F, 16'h0000, 1'b0, 1'b0, 7);
    checkOutput("rstop_reset", 32'(trA[5]), 32'(expReset()));
    checkOutput("rstop_refetch", 32'(trA[6]), 32'(expFetch(1'b0)));

    // illegal opcode: A traps and stays flagged, C falls back to FETCH
    applyStimulus(6'h11, 16'h0000, 1'b0, 1'b0, 12);
    checkOutput("exc_pre_illegal", 32'(trA[4].illegal), 32'd0);
    checkOutput("exc_except", 32'(trA[5]), 32'(expExcept()));
    checkOutput("exc_refetch", 32'(trA[6]), 32'(expFetch(1'b1)));
    checkOutput("exc_sticky", 32'(trA[11].illegal), 32'd1);
    checkOutput("exc_c_fetch", 32'(trC[5]), 32'(expFetch(1'b0)));
    checkOutput("exc_c_epc_cnt", 32'(countHigh(2, 3, 12)), 32'd0);
    checkOutput("exc_c_illegal", 32'(trC[11].illegal), 32'd0);

    // reset clears illegal; then abort lw in LW_READ with counter=2 (A index 6)
    applyStimulus(6'h23, 16'h0010, 1'b0, 1'b1, 6);
    checkOutput("abort_in_lwread", 32'(obsA), 32'(expMem(1'b0, 1'b0)));
    reset = 1'b1;
    stepCycle();
    checkOutput("abort_reset", 32'(obsA), 32'(expReset()));
    reset = 1'b0;
    mdrAfter = 0;
    regAfter = 0;
    for (int i = 0; i < 6; i++) begin
      mdrAfter += int'(aMdrWrite);
      regAfter += int'(aRegWrite);
      stepCycle();
    end
    checkOutput("abort_no_mdr", 32'(mdrAfter), 32'd0);
    checkOutput("abort_no_regwrite", 32'(regAfter), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
